// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared widths and FSM encoding for the RAM arbiter
package ram_arbiter_pkg;

    localparam int RAM_AW = 9;
    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2,
        WR_D  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - fetch and data requester handshake bundle
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic              if_req;
    logic [RAM_AW-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [RAM_AW-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [REG_AW-1:0] d_dst;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic [REG_AW-1:0] d_dstM;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_dst,
        input  if_valid, if_rdata, d_valid, d_rdata, d_dstM
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_dst,
        output if_valid, if_rdata, d_valid, d_rdata, d_dstM
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between fetch, data and program loader
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              working,
    input  logic              ld_wr,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    ram_arbiter_if.slave      bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wEn,
    output logic              ram_rEn,
    output logic [DATA_W-1:0] ram_wDat,
    input  logic [DATA_W-1:0] ram_rDat,
    output logic              busy,
    output logic [15:0]       if_stall_cnt
);

    state_t            state;
    logic              last_was_d;
    logic [RAM_AW-1:0] addr_q;
    logic [REG_AW-1:0] dst_q;
    logic              can_grant;
    logic              grant_d;
    logic              grant_if;

    // No grant while a valid pulse is out, so requesters get a cycle to drop req.
    always_comb begin
        can_grant = (state == IDLE) && working && !bus.if_valid && !bus.d_valid;
        grant_d   = can_grant && bus.d_req && !(last_was_d && bus.if_req);
        grant_if  = can_grant && bus.if_req && !grant_d;
    end

    always_comb begin
        ram_addr = addr_q;
        ram_wEn  = 1'b0;
        ram_rEn  = 1'b0;
        ram_wDat = bus.d_wdata;
        if (state == IDLE) begin
            if (!working) begin
                ram_addr = ld_addr;
                ram_wDat = ld_wdata;
                ram_wEn  = ld_wr;
            end else if (grant_d) begin
                ram_addr = bus.d_addr;
                ram_wEn  = bus.d_we;
                ram_rEn  = !bus.d_we;
            end else if (grant_if) begin
                ram_addr = bus.if_addr;
                ram_rEn  = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_was_d   <= 1'b0;
            addr_q       <= '0;
            dst_q        <= '0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
            bus.d_dstM   <= '0;
        end else begin
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        last_was_d <= 1'b1;
                        addr_q     <= bus.d_addr;
                        if (bus.d_we) begin
                            state <= WR_D;
                        end else begin
                            state <= RD_D;
                            dst_q <= bus.d_dst;
                        end
                    end else if (grant_if) begin
                        last_was_d <= 1'b0;
                        addr_q     <= bus.if_addr;
                        state      <= RD_IF;
                    end
                end
                // Dropping working mid-access abandons the completion pulse.
                RD_IF: begin
                    state <= IDLE;
                    if (working) begin
                        bus.if_rdata <= ram_rDat;
                        bus.if_valid <= 1'b1;
                    end
                end
                RD_D: begin
                    state <= IDLE;
                    if (working) begin
                        bus.d_rdata <= ram_rDat;
                        bus.d_dstM  <= dst_q;
                        bus.d_valid <= 1'b1;
                    end
                end
                WR_D: begin
                    state <= IDLE;
                    if (working) begin
                        bus.d_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(16)) u_stall (
        .clock (clock),
        .reset (reset),
        .inc   (working && bus.if_req && !grant_if),
        .count (if_stall_cnt)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with transaction-level model
module tb_ram_arbiter;

    logic        clock;
    logic        reset;
    logic        working;
    logic        ld_wr;
    logic [8:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic [8:0]  ram_addr;
    logic        ram_wEn;
    logic        ram_rEn;
    logic [31:0] ram_wDat;
    logic [31:0] ram_rDat;
    logic        busy;
    logic [15:0] if_stall_cnt;

    ram_arbiter_if bus();

    ram_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .working      (working),
        .ld_wr        (ld_wr),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .bus          (bus.slave),
        .ram_addr     (ram_addr),
        .ram_wEn      (ram_wEn),
        .ram_rEn      (ram_rEn),
        .ram_wDat     (ram_wDat),
        .ram_rDat     (ram_rDat),
        .busy         (busy),
        .if_stall_cnt (if_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The existing 512x32 synchronous RAM
    logic [31:0] ram_mem [512];
    always @(posedge clock) begin
        if (ram_wEn) ram_mem[ram_addr] <= ram_wDat;
        if (ram_rEn) ram_rDat <= ram_mem[ram_addr];
    end

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Behavioural model: one outstanding access, described by its grant cycle
    logic [31:0] m_mem [512];
    int          m_cyc, m_gcyc, m_free;
    bit          m_live, m_lwd;
    int          m_kind;            // 0 fetch, 1 load, 2 store
    logic [8:0]  m_paddr;
    logic [31:0] m_data, m_ifd, m_dd;
    logic [3:0]  m_pdst, m_dst;
    logic [15:0] m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, m_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_gcyc = -10; m_free = 0;
        m_live = 0; m_lwd = 0; m_kind = 0;
        m_paddr = '0; m_data = '0; m_ifd = '0; m_dd = '0;
        m_pdst = '0; m_dst = '0; m_stall = '0;
    endtask

    task automatic model_step();
        bit e_busy, e_ifv, e_dv, allowed, gd, gi, chk_addr;
        logic e_r, e_w;
        logic [8:0] e_addr;
        logic [31:0] e_wdat;
        e_busy = (m_cyc == m_gcyc + 1);
        e_ifv = 0; e_dv = 0;
        if (m_live && m_cyc == m_gcyc + 2) begin
            m_live = 0;
            if (m_kind == 0) begin
                e_ifv = 1; m_ifd = m_data;
            end else begin
                e_dv = 1;
                if (m_kind == 1) begin m_dd = m_data; m_dst = m_pdst; end
            end
        end
        allowed = working && !e_busy && (m_cyc >= m_free);
        gd = allowed && bus.d_req && !(m_lwd && bus.if_req);
        gi = allowed && bus.if_req && !gd;
        e_r = 0; e_w = 0; e_addr = m_paddr; e_wdat = '0; chk_addr = 1;
        if (!e_busy) begin
            if (!working) begin
                e_w = ld_wr; e_addr = ld_addr; e_wdat = ld_wdata;
            end else if (gd) begin
                e_addr = bus.d_addr; e_w = bus.d_we; e_r = !bus.d_we; e_wdat = bus.d_wdata;
            end else if (gi) begin
                e_addr = bus.if_addr; e_r = 1;
            end else begin
                chk_addr = 0;
            end
        end
        chk("busy", busy, e_busy);
        chk("if_valid", bus.if_valid, e_ifv);
        chk("d_valid", bus.d_valid, e_dv);
        chk("if_rdata", bus.if_rdata, m_ifd);
        chk("d_rdata", bus.d_rdata, m_dd);
        chk("d_dstM", bus.d_dstM, m_dst);
        chk("stall_cnt", if_stall_cnt, m_stall);
        chk("ram_rEn", ram_rEn, e_r);
        chk("ram_wEn", ram_wEn, e_w);
        if (chk_addr) chk("ram_addr", ram_addr, e_addr);
        if (e_w) chk("ram_wDat", ram_wDat, e_wdat);
        if (working && bus.if_req && !gi && m_stall != 16'hFFFF) m_stall++;
        if (e_w) m_mem[e_addr] = e_wdat;
        if (e_busy && !working) begin m_live = 0; m_free = m_gcyc + 2; end
        if (gd || gi) begin
            m_gcyc = m_cyc; m_free = m_cyc + 3; m_live = 1;
            m_paddr = e_addr; m_kind = gi ? 0 : (bus.d_we ? 2 : 1);
            m_data = m_mem[e_addr]; m_pdst = bus.d_dst; m_lwd = gd;
        end
        m_cyc++;
    endtask

    always @(negedge clock) if (chk_en) model_step();

    task automatic wait_cyc();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        chk_en = 0; ld_wr = 0; bus.d_we = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
        model_reset();
        chk_en = 1;
    endtask

    // Returns at the negedge of the valid cycle, or flags a timeout.
    task automatic wait_valid(input bit want_d, input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 16) begin
            @(negedge clock);
            seen = want_d ? bus.d_valid : bus.if_valid;
            if (!seen) wait_cyc();
            n++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout actual=no_valid required=valid", name);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ifv"}, bus.if_valid, 0);
        chk({tag, "_dv"}, bus.d_valid, 0);
        chk({tag, "_ifd"}, bus.if_rdata, 0);
        chk({tag, "_dd"}, bus.d_rdata, 0);
        chk({tag, "_dst"}, bus.d_dstM, 0);
        chk({tag, "_stall"}, if_stall_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; working = 0; ld_wr = 0; ld_addr = '0; ld_wdata = '0;
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_dst = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_vals("rst");
        wait_cyc();
        reset = 1; chk_en = 1;

        // Fill RAM through the loader so model and RAM agree everywhere
        for (int a = 0; a < 512; a++) begin
            working = 0; ld_wr = 1; ld_addr = 9'(a); ld_wdata = $urandom;
            wait_cyc();
        end

        // Program load then fetch
        working = 0; ld_wr = 1; ld_addr = 9'd5; ld_wdata = 32'hDEADBEEF;
        @(negedge clock);
        chk("ld_wen", ram_wEn, 1);
        chk("ld_addr", ram_addr, 5);
        wait_cyc();
        ld_wr = 0; working = 1; bus.if_req = 1; bus.if_addr = 9'd5; bus.d_req = 0;
        @(negedge clock);
        chk("fetch_ren", ram_rEn, 1);
        wait_cyc();
        @(negedge clock);
        chk("fetch_busy", busy, 1);
        chk("fetch_n1_ifv", bus.if_valid, 0);
        wait_cyc();
        @(negedge clock);
        chk("fetch_n2_ifv", bus.if_valid, 1);
        chk("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);
        wait_cyc();
        bus.if_req = 0;
        @(negedge clock);
        chk("fetch_pulse_end", bus.if_valid, 0);
        wait_cyc();

        // Store then load
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 9'h1F; bus.d_wdata = 32'h12345678;
        wait_valid(1, "store_valid");
        wait_cyc();
        bus.d_we = 0; bus.d_dst = 4'd7;
        wait_valid(1, "load_valid");
        chk("load_rdata", bus.d_rdata, 32'h12345678);
        chk("load_dstM", bus.d_dstM, 7);
        wait_cyc();
        bus.d_req = 0;
        wait_cyc();

        // Contention from reset release: data, fetch, data, fetch
        bus.d_req = 1; bus.d_addr = 9'h1F; bus.d_dst = 4'd3;
        bus.if_req = 1; bus.if_addr = 9'd5; working = 1;
        do_reset();
        bus.d_we = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("cont_dv", bus.d_valid, (k == 2 || k == 8));
            chk("cont_ifv", bus.if_valid, (k == 5 || k == 11));
            if (k == 2) begin
                chk("cont_drdata", bus.d_rdata, 32'h12345678);
                chk("cont_dstM", bus.d_dstM, 3);
            end
            if (k == 3) chk("cont_stall", if_stall_cnt, 3);
            if (k == 5) chk("cont_ifrdata", bus.if_rdata, 32'hDEADBEEF);
            wait_cyc();
        end
        bus.d_req = 0; bus.if_req = 0;
        repeat (3) wait_cyc();

        // Abort: working drops in the RD_D cycle
        do_reset();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'd5; bus.d_dst = 4'd9; working = 1;
        @(negedge clock);
        chk("abort_ren", ram_rEn, 1);
        wait_cyc();
        working = 0; bus.d_req = 0;
        @(negedge clock);
        chk("abort_busy1", busy, 1);
        wait_cyc();
        @(negedge clock);
        chk("abort_busy0", busy, 0);
        chk("abort_dv", bus.d_valid, 0);
        chk("abort_dstM", bus.d_dstM, 0);
        wait_cyc();
        @(negedge clock);
        chk("abort_dv_late", bus.d_valid, 0);
        wait_cyc();

        // Asynchronous reset in the middle of RD_IF
        working = 1; bus.if_req = 1; bus.if_addr = 9'd5;
        wait_valid(0, "pre_rst_fetch");
        chk("pre_rst_ifd", bus.if_rdata, 32'hDEADBEEF);
        wait_cyc();
        wait_cyc();
        chk("mid_rdif_busy", busy, 1);
        chk_en = 0;
        #2 reset = 0;
        #1 chk_reset_vals("async");
        bus.if_req = 0;
        wait_cyc();
        wait_cyc();
        reset = 1; model_reset(); chk_en = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_rst_ifv", bus.if_valid, 0);
            wait_cyc();
        end

        // Saturation of the stall counter
        working = 1; bus.if_req = 1; bus.if_addr = 9'd5; bus.d_req = 0;
        force dut.u_stall.count = 16'hFFFA;
        m_stall = 16'hFFFA;
        @(negedge clock);
        #1 release dut.u_stall.count;
        repeat (15) wait_cyc();
        @(negedge clock);
        chk("stall_sat", if_stall_cnt, 16'hFFFF);
        wait_cyc();
        repeat (6) wait_cyc();
        @(negedge clock);
        chk("stall_hold", if_stall_cnt, 16'hFFFF);
        wait_cyc();
        bus.if_req = 0;
        do_reset();

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            working     = ($urandom_range(0, 19) != 0);
            ld_wr       = ($urandom_range(0, 3) == 0);
            ld_addr     = 9'($urandom_range(0, 15));
            ld_wdata    = $urandom;
            bus.if_req  = ($urandom_range(0, 1) == 1);
            bus.if_addr = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
            bus.d_req   = ($urandom_range(0, 1) == 1);
            bus.d_we    = ($urandom_range(0, 1) == 1);
            bus.d_addr  = 9'($urandom_range(0, 15));
            bus.d_wdata = $urandom;
            bus.d_dst   = 4'($urandom_range(0, 15));
            wait_cyc();
        end
        bus.if_req = 0; bus.d_req = 0; working = 1; ld_wr = 0;
        repeat (4) wait_cyc();
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
